// File: rtl/regfile_pkg.sv
// Shared types and helpers for the regfile_sb register file.
// Holds the default geometry, the write-request payload, and the write
// resolution function used by both the write path and the forwarding path.
// Struct fields are sized for the largest supported geometry; narrower
// instances zero-extend into them.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_W_DEF = 24;
  localparam int unsigned REGFILE_DEPTH_DEF  = 16;

  // Upper bounds for the shared payload structs (DEPTH <= 256, DATA_W <= 64).
  localparam int unsigned REGFILE_AW_MAX     = 8;
  localparam int unsigned REGFILE_DATA_W_MAX = 64;

  typedef struct packed {
    logic                          en;
    logic [REGFILE_AW_MAX-1:0]     addr;
    logic [REGFILE_DATA_W_MAX-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic                          hit;
    logic [REGFILE_DATA_W_MAX-1:0] data;
  } wr_hit_t;

  // Does either write port target addr this cycle, and with what data.
  // wr1 (memory writeback) wins over wr0; address 0 never hits.
  function automatic wr_hit_t wr_resolve(input wr_req_t                   w0,
                                         input wr_req_t                   w1,
                                         input logic [REGFILE_AW_MAX-1:0] addr);
    wr_hit_t r;
    r = '0;
    if (addr != '0) begin
      if (w0.en && (w0.addr == addr)) begin
        r.hit  = 1'b1;
        r.data = w0.data;
      end
      if (w1.en && (w1.addr == addr)) begin
        r.hit  = 1'b1;
        r.data = w1.data;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the regfile_sb register file.
//   rd_addr/rd_data/rd_busy : NRD combinational read ports (port k in slice k)
//   wr0_*                   : ALU writeback port
//   wr1_*                   : memory writeback port (wins on address clash)
//   iss_en/iss_addr         : issue, marks destination register pending
//   busy_vec                : scoreboard state, bit i = register i pending
// master = decode/writeback side, slave = register file.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned  DATA_W = REGFILE_DATA_W_DEF,
  parameter int unsigned  DEPTH  = REGFILE_DEPTH_DEF,
  parameter int unsigned  NRD    = 2,
  localparam int unsigned AW     = $clog2(DEPTH)
);

  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;

  logic                  wr0_en;
  logic [AW-1:0]         wr0_addr;
  logic [DATA_W-1:0]     wr0_data;

  logic                  wr1_en;
  logic [AW-1:0]         wr1_addr;
  logic [DATA_W-1:0]     wr1_data;

  logic                  iss_en;
  logic [AW-1:0]         iss_addr;

  logic [DEPTH-1:0]      busy_vec;

  modport master (
    output rd_addr,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending-write scoreboard for regfile_sb.
// A register is marked pending when an instruction targeting it issues and
// cleared when either writeback port writes it. Issue beats a same-cycle
// writeback because the newly issued instruction is now the producer.
// Register 0 is never pending.
//   clk, rst             : clock, async active-high reset
//   i_wr0_en/i_wr0_addr  : ALU writeback (clears)
//   i_wr1_en/i_wr1_addr  : memory writeback (clears)
//   i_iss_en/i_iss_addr  : issue (sets)
//   o_busy_vec           : registered pending bits
module regfile_sb_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned  DEPTH = REGFILE_DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr0_en,
  input  logic [AW-1:0]    i_wr0_addr,
  input  logic             i_wr1_en,
  input  logic [AW-1:0]    i_wr1_addr,
  input  logic             i_iss_en,
  input  logic [AW-1:0]    i_iss_addr,
  output logic [DEPTH-1:0] o_busy_vec
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Next pending state: set dominates clear, otherwise hold.
  always_comb begin
    w_busy_nxt    = r_busy;
    w_busy_nxt[0] = 1'b0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (i_iss_en && (i_iss_addr == AW'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if ((i_wr0_en && (i_wr0_addr == AW'(i))) ||
                   (i_wr1_en && (i_wr1_addr == AW'(i)))) begin
        w_busy_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read, dual-write register file with a
// pending-write scoreboard, sitting between decode and writeback.
// Register 0 is hardwired to zero. Reads are combinational.
//   clk, rst : clock (rising edge), async active-high reset
//   bus      : regfile_sb_if slave (read ports, two write ports, issue,
//              scoreboard vector)
// Build option REGFILE_BYPASS_EN: forward same-cycle write data to the read
// ports (wr1 over wr0); without it a write is visible from the next cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned            DATA_W   = REGFILE_DATA_W_DEF,
  parameter int unsigned            DEPTH    = REGFILE_DEPTH_DEF,
  parameter int unsigned            NRD      = 2,
  localparam int unsigned           AW       = $clog2(DEPTH),
  parameter logic [DEPTH*DATA_W-1:0] RST_VALS = '0
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  wr_req_t           w_wr0;
  wr_req_t           w_wr1;
  logic [DEPTH-1:0]  w_wr_hit;
  logic [DATA_W-1:0] w_wr_data [DEPTH];
  logic [DEPTH-1:0]  w_busy_vec;

  // Narrow a resolved write back to this instance's data width.
  function automatic logic [DATA_W-1:0] hit_data(input wr_hit_t r);
    return DATA_W'(r.data);
  endfunction

  // Widen the bus write ports into the shared request payload.
  always_comb begin
    w_wr0      = '0;
    w_wr0.en   = bus.wr0_en;
    w_wr0.addr = REGFILE_AW_MAX'(bus.wr0_addr);
    w_wr0.data = REGFILE_DATA_W_MAX'(bus.wr0_data);
    w_wr1      = '0;
    w_wr1.en   = bus.wr1_en;
    w_wr1.addr = REGFILE_AW_MAX'(bus.wr1_addr);
    w_wr1.data = REGFILE_DATA_W_MAX'(bus.wr1_data);
  end

  // Per-register write decode; entry 0 never hits.
  always_comb begin
    wr_hit_t v_res;
    v_res = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v_res        = wr_resolve(w_wr0, w_wr1, REGFILE_AW_MAX'(i));
      w_wr_hit[i]  = v_res.hit;
      w_wr_data[i] = hit_data(v_res);
    end
  end

  // Storage: reset loads the image (entry 0 forced to zero).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_mem[i] <= RST_VALS[i*DATA_W +: DATA_W];
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_wr_hit[i]) begin
          r_mem[i] <= w_wr_data[i];
        end
      end
    end
  end

  regfile_sb_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_wr0_en   (bus.wr0_en),
    .i_wr0_addr (bus.wr0_addr),
    .i_wr1_en   (bus.wr1_en),
    .i_wr1_addr (bus.wr1_addr),
    .i_iss_en   (bus.iss_en),
    .i_iss_addr (bus.iss_addr),
    .o_busy_vec (w_busy_vec)
  );

  assign bus.busy_vec = w_busy_vec;

  // Read ports. Forwarding is suppressed while rst is high so the ports
  // show the reset image during reset.
  always_comb begin
    logic [AW-1:0]     v_addr;
    logic [DATA_W-1:0] v_data;
    logic              v_busy;
`ifdef REGFILE_BYPASS_EN
    wr_hit_t           v_fwd;
    v_fwd = '0;
`endif
    v_addr      = '0;
    v_data      = '0;
    v_busy      = 1'b0;
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      v_addr = bus.rd_addr[k*AW +: AW];
      v_data = r_mem[v_addr];
      v_busy = w_busy_vec[v_addr];
`ifdef REGFILE_BYPASS_EN
      v_fwd = wr_resolve(w_wr0, w_wr1, REGFILE_AW_MAX'(v_addr));
      if (!rst && v_fwd.hit) begin
        v_data = hit_data(v_fwd);
        // Forwarded value is final unless a new producer issues right now.
        v_busy = bus.iss_en && (bus.iss_addr == v_addr);
      end
`endif
      if (v_addr == '0) begin
        v_data = '0;
        v_busy = 1'b0;
      end
      bus.rd_data[k*DATA_W +: DATA_W] = v_data;
      bus.rd_busy[k]                  = v_busy;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (16 x 24-bit, two read ports).
// A behavioural model of storage and scoreboard produces expected values,
// which are queued when stimulus is applied and popped when outputs are read.
module tb_regfile_sb;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NRD   = 2;
  localparam int unsigned AW    = 4;
  localparam int unsigned IMG_W = DEPTH*DW;
  localparam logic [IMG_W-1:0] TB_RST =
    (IMG_W'(24'h40000) << (3*DW)) | (IMG_W'(24'h1CAC5) << (2*DW));

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;
  logic [31:0]      exp_q [$];

  regfile_sb_if #(.DATA_W(DW), .DEPTH(DEPTH), .NRD(NRD)) rf_if ();

  regfile_sb #(
    .DATA_W   (DW),
    .DEPTH    (DEPTH),
    .NRD      (NRD),
    .RST_VALS (TB_RST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = TB_RST[i*DW +: DW];
    m_mem[0] = '0;
    m_busy   = '0;
  endfunction

  task automatic model_edge();
    logic [DEPTH-1:0] nb;
    nb = m_busy;
    for (int i = 1; i < DEPTH; i++) begin
      logic wb;
      wb = 1'b0;
      if (rf_if.wr0_en && rf_if.wr0_addr == AW'(i)) begin m_mem[i] = rf_if.wr0_data; wb = 1'b1; end
      if (rf_if.wr1_en && rf_if.wr1_addr == AW'(i)) begin m_mem[i] = rf_if.wr1_data; wb = 1'b1; end
      if (rf_if.iss_en && rf_if.iss_addr == AW'(i)) nb[i] = 1'b1;
      else if (wb) nb[i] = 1'b0;
    end
    m_busy = nb;
  endtask

  function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
    if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rf_if.wr1_en && rf_if.wr1_addr == a) return rf_if.wr1_data;
    if (rf_if.wr0_en && rf_if.wr0_addr == a) return rf_if.wr0_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic m_rb(input logic [AW-1:0] a);
    if (a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if ((rf_if.wr1_en && rf_if.wr1_addr == a) || (rf_if.wr0_en && rf_if.wr0_addr == a))
      return rf_if.iss_en && (rf_if.iss_addr == a);
`endif
    return m_busy[a];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rf_if.wr0_en = 1'b0; rf_if.wr0_addr = '0; rf_if.wr0_data = '0;
    rf_if.wr1_en = 1'b0; rf_if.wr1_addr = '0; rf_if.wr1_data = '0;
    rf_if.iss_en = 1'b0; rf_if.iss_addr = '0;
  endtask

  task automatic tick();
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model();
    logic [AW-1:0] a0, a1;
    a0 = rf_if.rd_addr[0 +: AW];
    a1 = rf_if.rd_addr[AW +: AW];
    exp_q.push_back(32'(m_rd(a0)));
    exp_q.push_back(32'(m_rd(a1)));
    exp_q.push_back(32'(m_busy));
    exp_q.push_back(32'({m_rb(a1), m_rb(a0)}));
  endtask

  task automatic push_exp(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DEPTH-1:0] bv, input logic [1:0] rb);
    exp_q.push_back(32'(d0));
    exp_q.push_back(32'(d1));
    exp_q.push_back(32'(bv));
    exp_q.push_back(32'(rb));
  endtask

  function automatic logic [31:0] observe(input int s);
    case (s)
      0:       return 32'(rf_if.rd_data[0 +: DW]);
      1:       return 32'(rf_if.rd_data[DW +: DW]);
      2:       return 32'(rf_if.busy_vec);
      default: return 32'(rf_if.rd_busy);
    endcase
  endfunction

  function automatic string obs_name(input int s);
    case (s)
      0:       return "rd_data0";
      1:       return "rd_data1";
      2:       return "busy_vec";
      default: return "rd_busy";
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rf_if.rd_addr = {4'd3, 4'd2};
    push_exp(24'h1CAC5, 24'h40000, 16'h0000, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL reset.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rf_if.rd_addr = {4'd1, 4'd0};
    push_exp(24'h0, 24'h0, 16'h0000, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL reset_release.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
  endtask

  task automatic test_write_collision();
    rf_if.rd_addr  = {4'd5, 4'd5};
    rf_if.wr0_en   = 1'b1; rf_if.wr0_addr = 4'd5; rf_if.wr0_data = 24'hABCDE;
    rf_if.wr1_en   = 1'b1; rf_if.wr1_addr = 4'd5; rf_if.wr1_data = 24'h12345;
    tick(); idle();
    push_exp(24'h12345, 24'h12345, 16'h0000, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL wr_collision.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
    // Writes and issue to register 0 have no effect.
    rf_if.rd_addr  = {4'd0, 4'd0};
    rf_if.wr0_en   = 1'b1; rf_if.wr0_addr = 4'd0; rf_if.wr0_data = 24'hFFFFF;
    rf_if.wr1_en   = 1'b1; rf_if.wr1_addr = 4'd0; rf_if.wr1_data = 24'hFFFFF;
    rf_if.iss_en   = 1'b1; rf_if.iss_addr = 4'd0;
    tick(); idle();
    push_exp(24'h0, 24'h0, 16'h0000, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL wr_reg0.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
  endtask

  task automatic test_issue();
    rf_if.rd_addr = {4'd7, 4'd5};
    rf_if.iss_en  = 1'b1; rf_if.iss_addr = 4'd7;
    tick(); idle();
    push_exp(24'h12345, 24'h0, 16'h0080, 2'b10);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL issue_set.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
    rf_if.wr0_en = 1'b1; rf_if.wr0_addr = 4'd7; rf_if.wr0_data = 24'h00042;
    tick(); idle();
    push_exp(24'h12345, 24'h00042, 16'h0000, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL issue_clear.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
  endtask

  task automatic test_issue_beats_wb();
    rf_if.rd_addr = {4'd9, 4'd9};
    rf_if.iss_en  = 1'b1; rf_if.iss_addr = 4'd9;
    tick();
    rf_if.wr1_en = 1'b1; rf_if.wr1_addr = 4'd9; rf_if.wr1_data = 24'h5A5A5;
    tick(); idle();
    push_exp(24'h5A5A5, 24'h5A5A5, 16'h0200, 2'b11);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL issue_vs_wb.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
  endtask

  task automatic test_bypass();
    rf_if.rd_addr = {4'd4, 4'd4};
    rf_if.wr0_en  = 1'b1; rf_if.wr0_addr = 4'd4; rf_if.wr0_data = 24'h0BEEF;
`ifdef REGFILE_BYPASS_EN
    push_exp(24'h0BEEF, 24'h0BEEF, 16'h0200, 2'b00);
`else
    push_exp(24'h0, 24'h0, 16'h0200, 2'b00);
`endif
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL bypass_same.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
    tick(); idle();
    push_exp(24'h0BEEF, 24'h0BEEF, 16'h0200, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL bypass_next.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
    // Both ports write 4 and a new producer issues to 4 in the same cycle.
    rf_if.wr0_en = 1'b1; rf_if.wr0_addr = 4'd4; rf_if.wr0_data = 24'h0D00D;
    rf_if.wr1_en = 1'b1; rf_if.wr1_addr = 4'd4; rf_if.wr1_data = 24'h0CAFE;
    rf_if.iss_en = 1'b1; rf_if.iss_addr = 4'd4;
`ifdef REGFILE_BYPASS_EN
    push_exp(24'h0CAFE, 24'h0CAFE, 16'h0200, 2'b11);
`else
    push_exp(24'h0BEEF, 24'h0BEEF, 16'h0200, 2'b00);
`endif
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL bypass_prio.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
    tick(); idle();
    rf_if.wr0_en = 1'b1; rf_if.wr0_addr = 4'd4; rf_if.wr0_data = 24'h0CAFE;
    rf_if.iss_en = 1'b1; rf_if.iss_addr = 4'd7;
    tick(); idle();
    push_exp(24'h0CAFE, 24'h0CAFE, 16'h0280, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL bypass_after.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
  endtask

  task automatic test_midreset();
    rf_if.rd_addr = {4'd9, 4'd3};
    push_exp(24'h40000, 24'h5A5A5, 16'h0280, 2'b10);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL pre_reset.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
    rf_if.wr1_en = 1'b1; rf_if.wr1_addr = 4'd3; rf_if.wr1_data = 24'h55555;
    rst = 1'b1;
    model_reset();
    push_exp(24'h40000, 24'h0, 16'h0000, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL async_reset.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
    tick();
    rst = 1'b0;
    idle();
    tick();
    push_exp(24'h40000, 24'h0, 16'h0000, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL write_lost.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
    rf_if.wr1_en = 1'b1; rf_if.wr1_addr = 4'd3; rf_if.wr1_data = 24'h55555;
    tick(); idle();
    push_exp(24'h55555, 24'h0, 16'h0000, 2'b00);
    #1;
    for (int s = 0; s < 4; s++) begin
      logic [31:0] e;
      e = exp_q.pop_front(); n_tests++;
      if (observe(s) !== e) begin
        n_fail++;
        $display("FAIL post_reset.%s: got %h, expected %h", obs_name(s), observe(s), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      rf_if.rd_addr  = {AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1))};
      rf_if.wr0_en   = 1'($urandom_range(0, 1));
      rf_if.wr0_addr = AW'($urandom_range(0, DEPTH-1));
      rf_if.wr0_data = DW'($urandom);
      rf_if.wr1_en   = 1'($urandom_range(0, 1));
      rf_if.wr1_addr = AW'($urandom_range(0, DEPTH-1));
      rf_if.wr1_data = DW'($urandom);
      rf_if.iss_en   = 1'($urandom_range(0, 1));
      rf_if.iss_addr = AW'($urandom_range(0, DEPTH-1));
      push_model();
      #1;
      for (int s = 0; s < 4; s++) begin
        logic [31:0] e;
        e = exp_q.pop_front(); n_tests++;
        if (observe(s) !== e) begin
          n_fail++;
          $display("FAIL b2b[%0d].%s: got %h, expected %h", n, obs_name(s), observe(s), e);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    rf_if.rd_addr = '0;
    idle();
    #1;
    rst = 1'b1;
    model_reset();
    test_reset();
    test_write_collision();
    test_issue();
    test_issue_beats_wb();
    test_bypass();
    test_midreset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 16 x 24-bit, 2R/1W register file, for the pipelined core.
- Configurable data width, depth and read-port count; two write ports (ALU and memory writeback); hardwired-zero register 0.
- Per-register pending-write scoreboard, set at issue and cleared at writeback, so decode can detect RAW hazards.
- Sits between decode (read, issue) and writeback (write, clear).

Parameters:
DATA_W, 24, register width in bits
DEPTH, 16, number of registers; power of 2, >= 2
NRD, 2, number of read ports, 1..4
AW, $clog2(DEPTH), address width (derived, not overridden)
RST_VALS, '0, packed DEPTH*DATA_W reset image; entry i occupies bits [i*DATA_W +: DATA_W]; entry 0 ignored

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW]
rd_data  out  NRD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
rd_busy  out  NRD  port k address has a pending write
wr0_en  in  1  write port 0 enable (ALU writeback)
wr0_addr  in  AW  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (memory writeback)
wr1_addr  in  AW  write port 1 address
wr1_data  in  DATA_W  write port 1 data
iss_en  in  1  issue: mark iss_addr pending
iss_addr  in  AW  destination of issued instruction
busy_vec  out  DEPTH  scoreboard state, bit i = register i pending

Behaviour:
- Reset: reset is rst, asynchronous, active-high; clock is clk.
  - Register i (i > 0) loads RST_VALS entry i.
  - Register 0 holds 0; busy_vec clears to 0.
  - During reset rd_data shows the reset image (0 for address 0) and rd_busy = 0.
- Reads are combinational, zero latency.
  - Address 0 always reads 0 with rd_busy = 0.
  - Out-of-range addresses cannot occur: DEPTH is a power of 2.
- Writes commit at the rising edge of clk when enabled.
  - Writes to address 0 are discarded and never clear or set busy.
  - If wr0 and wr1 target the same address in one cycle, wr1 wins.
- Scoreboard, per register i > 0, updated at the clock edge:
  - set = iss_en & iss_addr == i
  - clr = (wr0_en & wr0_addr == i) | (wr1_en & wr1_addr == i)
  - next = set ? 1 : (clr ? 0 : cur). Issue beats same-cycle writeback, since the new producer owns the register.
- Re-issue to a busy register keeps it busy. There is no counter; the single outstanding producer per register is guaranteed by decode.
- iss_en to address 0 is ignored.
- rst asserted mid-operation immediately overrides all pending writes and scoreboard state. The first edge after deassertion behaves normally.

Optional Feature:
- REGFILE_BYPASS_EN defined: write-to-read forwarding.
  - If a read address matches an enabled write address (non-zero) in the same cycle, rd_data returns that write data, with wr1 priority over wr0.
  - rd_busy for that port is 0 unless iss_en targets the same address in that cycle.
- Undefined: rd_data and rd_busy reflect registered state only. A same-cycle write becomes visible the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - REGFILE_DATA_W_DEF = 24 and REGFILE_DEPTH_DEF = 16 constants
  - typedef of the write request struct {en, addr, data}
  - function wr_resolve(w0, w1, addr) returning {hit, data} with wr1 priority, used by both the write logic and the bypass
- One sub-module, regfile_sb_scoreboard: busy_vec flops plus set/clear logic. The storage array and read muxes stay in the top.

Test Plan:
1. Reset, RST_VALS entry 2 = 24'h1CAC5, entry 3 = 24'h40000 -> rd_addr{2,3} read 24'h1CAC5 / 24'h40000, busy_vec = 0; release rst, read addr 0 -> 0.
2. wr0 (addr 5, 24'hABCDE) and wr1 (addr 5, 24'h12345) in the same cycle -> next cycle addr 5 reads 24'h12345. Write 24'hFFFFF to addr 0 -> reads 0.
3. iss_en addr 7 -> busy_vec[7] = 1, rd_busy = 1 for a port reading 7. wr0 to 7 with 24'h00042 -> busy_vec[7] = 0, data 24'h00042.
4. Same cycle iss_en addr 9 and wr1 addr 9 (busy) -> busy_vec[9] stays 1, data updated.
5. REGFILE_BYPASS_EN: wr0 addr 4 = 24'h0BEEF while rd_addr = 4 -> rd_data = 24'h0BEEF in the same cycle. Undefined: old value that cycle, 24'h0BEEF the next.
6. Assert rst mid-stream with busy_vec = 16'h0280 and wr1_en active -> busy_vec = 0 and registers at reset image immediately; the write is lost.
